// File: rtl/interval_timer_if.sv
// Signal bundle between the interval timer, the security FSM and the
// time-parameter store.
interface interval_timer_if;
    logic       startTimer;
    logic [1:0] intervalSelect;
    logic [3:0] value;
    logic [1:0] interval;
    logic       expired;
    logic       running;
    logic       oneHzEnable;
    logic [3:0] countRemaining;

    // Timer side.
    modport slave (
        input  startTimer,
        input  intervalSelect,
        input  value,
        output interval,
        output expired,
        output running,
        output oneHzEnable,
        output countRemaining
    );

    // FSM / parameter-store side.
    modport master (
        output startTimer,
        output intervalSelect,
        output value,
        input  interval,
        input  expired,
        input  running,
        input  oneHzEnable,
        input  countRemaining
    );
endinterface

// File: rtl/interval_timer.sv
// Countdown timer: fetches a seconds value from the parameter store on request
// and counts it down on a divided one-second tick, pulsing expired at zero.
module interval_timer #(
    parameter int unsigned CLK_TICKS_PER_SEC = 27000000,
    parameter int unsigned DIV_WIDTH         = 25
) (
    input  logic              clock,
    input  logic              systemReset,
    interval_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLK_TICKS_PER_SEC - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] divider_q, divider_d;
    logic [1:0]           interval_q, interval_d;
    logic [3:0]           count_q, count_d;
    logic                 expired_q, expired_d;
    logic                 running_q, running_d;
    logic                 tick_q, tick_d;

    // Next-state logic; a start request overrides whatever the timer is doing.
    always_comb begin
        state_d    = state_q;
        interval_d = interval_q;
        count_d    = count_q;
        expired_d  = 1'b0;
        divider_d  = (divider_q == DIV_LAST) ? {DIV_WIDTH{1'b0}} : divider_q + DIV_ONE;
        if (bus.startTimer) begin
            interval_d = bus.intervalSelect;
            divider_d  = {DIV_WIDTH{1'b0}};
            state_d    = LOAD;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                LOAD: begin
                    count_d = bus.value;
                    if (bus.value == 4'd0) begin
                        expired_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    if (tick_q) begin
                        // A count of 1 (or a defensive 0) ends the run without wrapping.
                        if (count_q <= 4'd1) begin
                            count_d   = 4'd0;
                            expired_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            count_d   = count_q - 4'd1;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        // running stays up through the expiry pulse cycle.
        running_d = (state_d != IDLE) || expired_d;
        tick_d    = (divider_d == DIV_LAST);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (systemReset) begin
            state_q    <= IDLE;
            divider_q  <= {DIV_WIDTH{1'b0}};
            interval_q <= 2'b00;
            count_q    <= 4'd0;
            expired_q  <= 1'b0;
            running_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            divider_q  <= divider_d;
            interval_q <= interval_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            running_q  <= running_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.interval       = interval_q;
    assign bus.expired        = expired_q;
    assign bus.running        = running_q;
    assign bus.oneHzEnable    = tick_q;
    assign bus.countRemaining = count_q;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios plus random
// stimulus, checked every cycle against a cycle-arithmetic reference model.
module tb_interval_timer;

    localparam int TPS = 4;

    logic clock;
    logic systemReset;
    interval_timer_if bus ();

    logic [3:0] params [4];

    interval_timer #(.CLK_TICKS_PER_SEC(TPS), .DIV_WIDTH(3)) dut (
        .clock       (clock),
        .systemReset (systemReset),
        .bus         (bus)
    );

    assign bus.value = params[bus.interval];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int act, input int exp, input int c);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, c, act, exp);
        end
    endtask

    // Reference model: a run started in cycle s with value v shows v from s+2,
    // loses one per second, and expires in cycle s+TPS*v+1 (s+2 when v is 0).
    int cyc = 0;
    bit mdl_valid = 1'b0;
    bit run_act   = 1'b0;
    int start_c, val, exp_c, cnt_hold, anchor, sel_exp;
    int e_cnt;
    bit e_run, e_exp, e_tick;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mdl_valid) begin
            if (run_act && cyc == start_c + 1) begin
                val   = int'(params[sel_exp]);
                exp_c = (val == 0) ? start_c + 2 : start_c + TPS * val + 1;
            end
            e_cnt  = (run_act && cyc >= start_c + 2 && cyc <= exp_c)
                     ? val - (cyc - start_c - 1) / TPS : cnt_hold;
            e_run  = run_act && cyc >= start_c + 1 && cyc <= exp_c;
            e_exp  = run_act && cyc == exp_c;
            e_tick = ((cyc - anchor) % TPS) == (TPS - 1);
            check_eq("interval", int'(bus.interval), sel_exp, cyc);
            check_eq("count", int'(bus.countRemaining), e_cnt, cyc);
            check_eq("running", int'(bus.running), int'(e_run), cyc);
            check_eq("expired", int'(bus.expired), int'(e_exp), cyc);
            check_eq("oneHz", int'(bus.oneHzEnable), int'(e_tick), cyc);
            if (run_act && cyc >= exp_c) begin
                run_act  = 1'b0;
                cnt_hold = 0;
            end
        end
        if (systemReset) begin
            mdl_valid = 1'b1;
            run_act   = 1'b0;
            cnt_hold  = 0;
            sel_exp   = 0;
            anchor    = cyc + 1;
        end else if (mdl_valid && bus.startTimer) begin
            cnt_hold = e_cnt;
            run_act  = 1'b1;
            start_c  = cyc;
            sel_exp  = int'(bus.intervalSelect);
            anchor   = cyc + 1;
        end
    end

    task automatic step(input logic st, input logic [1:0] sel, input logic rst);
        @(posedge clock);
        #1;
        bus.startTimer     = st;
        bus.intervalSelect = sel;
        systemReset        = rst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0);
    endtask

    task automatic defaults();
        params[0] = 4'd6;
        params[1] = 4'd8;
        params[2] = 4'd15;
        params[3] = 4'd10;
    endtask

    initial begin
        bus.startTimer     = 1'b0;
        bus.intervalSelect = 2'b00;
        systemReset        = 1'b1;
        defaults();
        step(1'b0, 2'b00, 1'b1);
        idle(3);

        // Arm delay of 6 s.
        step(1'b1, 2'b00, 1'b0);
        idle(30);

        // Zero-length interval expires straight out of LOAD.
        params[0] = 4'd0;
        step(1'b1, 2'b00, 1'b0);
        idle(6);
        params[0] = 4'd6;

        // Passenger run abandoned by a driver restart 20 cycles in.
        step(1'b1, 2'b10, 1'b0);
        idle(19);
        step(1'b1, 2'b01, 1'b0);
        idle(40);

        // Restart coincident with the first tick of a run.
        step(1'b1, 2'b11, 1'b0);
        idle(3);
        step(1'b1, 2'b01, 1'b0);
        idle(40);

        // Reset in the middle of an alarm-on run.
        step(1'b1, 2'b11, 1'b0);
        idle(9);
        step(1'b0, 2'b00, 1'b1);
        idle(15);

        // Driver delay reprogrammed mid-run only affects the next start.
        step(1'b1, 2'b01, 1'b0);
        idle(10);
        params[1] = 4'd3;
        idle(26);
        step(1'b1, 2'b01, 1'b0);
        idle(20);
        defaults();

        // Random mix of starts, resets and reprogramming.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
            end else if (r < 10) begin
                step(1'b0, 2'b00, 1'b1);
            end else begin
                step(1'b0, 2'b00, 1'b0);
                if (r < 16) params[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
            end
        end
        idle(70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
